branch_resolve_ctrl: RTL and testbench

// Execute-stage branch resolution controller for the RV32I pipeline. Sits behind the branch comparator.

---
 rtl/branch_resolve_ctrl.sv | 166 ++++++++++++++++
 tb/tb_branch_resolve_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_ctrl.sv
// Execute-stage branch resolution: decides taken/not-taken, checks the fetch
// prediction, sequences redirect + flush, and owns the bimodal predictor table.
module branch_resolve_ctrl #(
    parameter int AWIDTH       = 32,
    parameter int DWIDTH       = 32,
    parameter int BHT_ENTRIES  = 16,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              br_valid_i,
    output logic              br_ready_o,
    input  logic [6:0]        opcode_i,
    input  logic [2:0]        funct3_i,
    input  logic [AWIDTH-1:0] pc_i,
    input  logic [DWIDTH-1:0] imm_i,
    input  logic [DWIDTH-1:0] rs1_i,
    input  logic              breq_i,
    input  logic              brlt_i,
    input  logic              pred_taken_i,
    input  logic [AWIDTH-1:0] fetch_pc_i,
    output logic              pred_taken_o,
    output logic              redirect_o,
    output logic [AWIDTH-1:0] redirect_pc_o,
    output logic              flush_o,
    output logic [31:0]       mispred_cnt_o
);
    localparam int IDXW = (BHT_ENTRIES > 1) ? $clog2(BHT_ENTRIES) : 1;
    localparam int CW   = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CW-1:0] FLUSH_INIT = (FLUSH_CYCLES > 0) ? CW'(FLUSH_CYCLES - 1) : '0;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [1:0] {IDLE, REDIRECT, FLUSH} state_t;

    state_t            state_reg;
    logic [CW-1:0]     flush_cnt_reg;
    logic              redirect_reg;
    logic              flush_reg;
    logic [AWIDTH-1:0] redirect_pc_reg;
    logic [31:0]       mispred_cnt_reg;

    logic              is_branch, is_jal, is_jalr;
    logic              br_cond, taken, mispred, accept, bht_upd;
    logic [AWIDTH-1:0] imm_a, rs1_a, jalr_sum, target, correct_pc;
    logic [IDXW-1:0]   upd_idx, fetch_idx;

    logic [1:0] bht_reg  [BHT_ENTRIES];
    logic [1:0] bht_next [BHT_ENTRIES];

    logic unused_fetch_bits;
    assign unused_fetch_bits = ^{fetch_pc_i[AWIDTH-1:IDXW+2], fetch_pc_i[1:0]};

    assign imm_a = imm_i[AWIDTH-1:0];
    assign rs1_a = rs1_i[AWIDTH-1:0];

    assign is_branch = (opcode_i == OP_BRANCH);
    assign is_jal    = (opcode_i == OP_JAL);
    assign is_jalr   = (opcode_i == OP_JALR);

    always_comb begin
        br_cond = 1'b0;
        case (funct3_i)
            3'b000:          br_cond = breq_i;
            3'b001:          br_cond = !breq_i;
            3'b100, 3'b110:  br_cond = brlt_i;
            3'b101, 3'b111:  br_cond = !brlt_i;
            default:         br_cond = 1'b0;
        endcase
    end

    assign taken      = is_branch ? br_cond : (is_jal || is_jalr);
    assign jalr_sum   = rs1_a + imm_a;
    assign target     = is_jalr ? {jalr_sum[AWIDTH-1:1], 1'b0} : (pc_i + imm_a);
    assign correct_pc = taken ? target : (pc_i + AWIDTH'(4));

    // JALR has no target prediction, so it always costs a redirect.
    assign mispred = is_branch ? (taken != pred_taken_i)
                   : is_jal    ? !pred_taken_i
                   : is_jalr;

    assign br_ready_o = (state_reg == IDLE) && !reset;
    assign accept     = br_valid_i && br_ready_o;
    assign bht_upd    = accept && is_branch && (funct3_i[2:1] != 2'b01);

    assign upd_idx   = pc_i[IDXW+1:2];
    assign fetch_idx = fetch_pc_i[IDXW+1:2];

    generate
        for (genvar gi = 0; gi < BHT_ENTRIES; gi++) begin : g_bht
            logic [1:0] cur;
            logic       hit;
            assign cur = bht_reg[gi];
            assign hit = bht_upd && (upd_idx == IDXW'(gi));
            assign bht_next[gi] = !hit    ? cur
                                : br_cond ? ((cur == 2'b11) ? cur : cur + 2'd1)
                                :           ((cur == 2'b00) ? cur : cur - 2'd1);
        end
    endgenerate

    // Lookup reads the registered table, so a same-cycle update is seen next cycle.
    assign pred_taken_o = bht_reg[fetch_idx][1];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht_reg[i] <= 2'b01;
            end
        end else begin
            bht_reg <= bht_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= IDLE;
            flush_cnt_reg   <= '0;
            redirect_reg    <= 1'b0;
            flush_reg       <= 1'b0;
            redirect_pc_reg <= '0;
            mispred_cnt_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept && mispred) begin
                        redirect_pc_reg <= correct_pc;
                        mispred_cnt_reg <= mispred_cnt_reg + 32'd1;
                        redirect_reg    <= 1'b1;
                        flush_reg       <= 1'b1;
                        state_reg       <= REDIRECT;
                    end
                end
                REDIRECT: begin
                    redirect_reg <= 1'b0;
                    if (FLUSH_CYCLES == 0) begin
                        flush_reg <= 1'b0;
                        state_reg <= IDLE;
                    end else begin
                        flush_cnt_reg <= FLUSH_INIT;
                        state_reg     <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (flush_cnt_reg == '0) begin
                        flush_reg <= 1'b0;
                        state_reg <= IDLE;
                    end else begin
                        flush_cnt_reg <= flush_cnt_reg - CW'(1);
                    end
                end
                default: begin
                    redirect_reg <= 1'b0;
                    flush_reg    <= 1'b0;
                    state_reg    <= IDLE;
                end
            endcase
        end
    end

    assign redirect_o    = redirect_reg;
    assign flush_o       = flush_reg;
    assign redirect_pc_o = redirect_pc_reg;
    assign mispred_cnt_o = mispred_cnt_reg;
endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Bench for branch_resolve_ctrl: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_branch_resolve_ctrl;
    localparam int FC = 2;
    localparam int NE = 16;
    localparam logic [6:0] BR   = 7'b1100011;
    localparam logic [6:0] JAL  = 7'b1101111;
    localparam logic [6:0] JALR = 7'b1100111;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        br_valid_i = 1'b0;
    logic        br_ready_o;
    logic [6:0]  opcode_i = '0;
    logic [2:0]  funct3_i = '0;
    logic [31:0] pc_i = '0, imm_i = '0, rs1_i = '0, fetch_pc_i = '0;
    logic        breq_i = 1'b0, brlt_i = 1'b0, pred_taken_i = 1'b0;
    logic        pred_taken_o, redirect_o, flush_o;
    logic [31:0] redirect_pc_o, mispred_cnt_o;

    branch_resolve_ctrl dut (
        .clk(clk), .reset(reset), .br_valid_i(br_valid_i), .br_ready_o(br_ready_o),
        .opcode_i(opcode_i), .funct3_i(funct3_i), .pc_i(pc_i), .imm_i(imm_i),
        .rs1_i(rs1_i), .breq_i(breq_i), .brlt_i(brlt_i), .pred_taken_i(pred_taken_i),
        .fetch_pc_i(fetch_pc_i), .pred_taken_o(pred_taken_o), .redirect_o(redirect_o),
        .redirect_pc_o(redirect_pc_o), .flush_o(flush_o), .mispred_cnt_o(mispred_cnt_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: the redirect/flush window is just a count of busy cycles.
    logic        m_valid = 1'b0;
    logic        m_acc = 1'b0;
    int          m_busy = 0;
    logic [31:0] m_rpc = '0, m_cnt = '0;
    int          m_bht[NE];

    function automatic void resolve(input logic [6:0] op, input logic [2:0] f3,
                                    input logic [31:0] pc, input logic [31:0] imm,
                                    input logic [31:0] rs1, input logic eq, input logic lt,
                                    input logic pr, output logic mis,
                                    output logic [31:0] cpc, output int upd);
        logic tk;
        logic [31:0] tgt;
        tk = 1'b0; mis = 1'b0; upd = -1; tgt = pc + imm;
        if (op == BR) begin
            case (f3)
                3'd0: tk = eq;
                3'd1: tk = !eq;
                3'd4, 3'd6: tk = lt;
                3'd5, 3'd7: tk = !lt;
                default: tk = 1'b0;
            endcase
            mis = (tk != pr);
            if (f3 != 3'd2 && f3 != 3'd3) upd = tk ? 1 : 0;
        end else if (op == JAL) begin
            tk = 1'b1; mis = !pr;
        end else if (op == JALR) begin
            tk = 1'b1; mis = 1'b1; tgt = (rs1 + imm) & 32'hFFFF_FFFE;
        end
        cpc = tk ? tgt : pc + 32'd4;
    endfunction

    always @(negedge clk) begin
        logic mis;
        logic [31:0] cpc;
        int upd, ix;
        if (m_valid) begin
            chk("ready", {31'd0, br_ready_o}, {31'd0, (m_busy == 0) && !reset});
            chk("redirect", {31'd0, redirect_o}, {31'd0, m_busy == FC + 1});
            chk("flush", {31'd0, flush_o}, {31'd0, m_busy > 0});
            chk("redirect_pc", redirect_pc_o, m_rpc);
            chk("mispred_cnt", mispred_cnt_o, m_cnt);
            chk("pred_taken", {31'd0, pred_taken_o}, {31'd0, m_bht[fetch_pc_i[5:2]] >= 2});
        end
        m_acc = 1'b0;
        if (reset) begin
            m_valid = 1'b1; m_busy = 0; m_rpc = '0; m_cnt = '0;
            for (int i = 0; i < NE; i++) m_bht[i] = 1;
        end else if (m_valid) begin
            if (m_busy > 0) begin
                m_busy--;
            end else if (br_valid_i) begin
                m_acc = 1'b1;
                resolve(opcode_i, funct3_i, pc_i, imm_i, rs1_i, breq_i, brlt_i,
                        pred_taken_i, mis, cpc, upd);
                if (mis) begin
                    m_busy = FC + 1; m_rpc = cpc; m_cnt = m_cnt + 32'd1;
                end
                ix = int'(pc_i[5:2]);
                if (upd == 1 && m_bht[ix] < 3) m_bht[ix]++;
                if (upd == 0 && m_bht[ix] > 0) m_bht[ix]--;
                $display("txn op=%b f3=%0d pc=%h imm=%h mis=%0b cpc=%h", opcode_i, funct3_i,
                         pc_i, imm_i, mis, cpc);
            end
        end
    end

    task automatic sync();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        br_valid_i = 1'b0; reset = 1'b1;
        sync();
        reset = 1'b0; #1;
    endtask

    task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] pc,
                         input logic [31:0] imm, input logic [31:0] rs1, input logic eq,
                         input logic lt, input logic pr, output int waited);
        opcode_i = op; funct3_i = f3; pc_i = pc; imm_i = imm; rs1_i = rs1;
        breq_i = eq; brlt_i = lt; pred_taken_i = pr; br_valid_i = 1'b1;
        waited = 0;
        do begin
            sync();
            waited++;
        end while (!m_acc && waited < 50);
        if (!m_acc) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int w, fl, nr, sel, iv;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0; #1;

        // 1: reset state and predictor table
        chk("t1_ready", {31'd0, br_ready_o}, 32'd1);
        chk("t1_redirect", {31'd0, redirect_o}, 32'd0);
        chk("t1_flush", {31'd0, flush_o}, 32'd0);
        chk("t1_cnt", mispred_cnt_o, 32'd0);
        for (int a = 0; a < 64; a += 4) begin
            fetch_pc_i = 32'(a); #1;
            chk("t1_bht", {31'd0, pred_taken_o}, 32'd0);
        end
        sync();

        // 2: BEQ mispredict, redirect then 3 flush cycles
        issue(BR, 3'd0, 32'h100, 32'h20, 32'h0, 1'b1, 1'b0, 1'b0, w);
        br_valid_i = 1'b0;
        chk("t2_redirect", {31'd0, redirect_o}, 32'd1);
        chk("t2_rpc", redirect_pc_o, 32'h120);
        chk("t2_cnt", mispred_cnt_o, 32'd1);
        fetch_pc_i = 32'h100; #1;
        chk("t2_bht", {31'd0, pred_taken_o}, 32'd1);
        fl = 0; nr = 0;
        for (int k = 0; k < 5; k++) begin
            if (flush_o) fl++;
            if (!br_ready_o) nr++;
            sync();
        end
        chk("t2_flush_len", 32'(fl), 32'd3);
        chk("t2_notready_len", 32'(nr), 32'd3);

        // 3: correct BLTU then ADDI back-to-back
        do_reset();
        sync();
        issue(BR, 3'd6, 32'h40, 32'h10, 32'h0, 1'b0, 1'b1, 1'b1, w);
        issue(7'b0010011, 3'd0, 32'h44, 32'h1, 32'h0, 1'b0, 1'b0, 1'b0, w);
        br_valid_i = 1'b0;
        chk("t3_b2b_wait", 32'(w), 32'd1);
        chk("t3_redirect", {31'd0, redirect_o}, 32'd0);
        chk("t3_flush", {31'd0, flush_o}, 32'd0);
        chk("t3_cnt", mispred_cnt_o, 32'd0);

        // 4: JALR target alignment, JAL wrap-around
        issue(JALR, 3'd0, 32'h80, 32'h4, 32'h2003, 1'b0, 1'b0, 1'b1, w);
        br_valid_i = 1'b0;
        chk("t4_jalr_rpc", redirect_pc_o, 32'h2006);
        chk("t4_jalr_cnt", mispred_cnt_o, 32'd1);
        issue(JAL, 3'd0, 32'hFFFF_FFF0, 32'h20, 32'h0, 1'b0, 1'b0, 1'b0, w);
        br_valid_i = 1'b0;
        chk("t4_jal_rpc", redirect_pc_o, 32'h10);
        chk("t4_jal_cnt", mispred_cnt_o, 32'd2);

        // 5: saturation and old-value read in the update cycle
        do_reset();
        fetch_pc_i = 32'h8;
        sync();
        chk("t5_init", {31'd0, pred_taken_o}, 32'd0);
        repeat (5) issue(BR, 3'd0, 32'h8, 32'h40, 32'h0, 1'b1, 1'b0, 1'b1, w);
        chk("t5_sat", {31'd0, pred_taken_o}, 32'd1);
        issue(BR, 3'd0, 32'h8, 32'h40, 32'h0, 1'b0, 1'b0, 1'b1, w);
        br_valid_i = 1'b0;
        chk("t5_dec", {31'd0, pred_taken_o}, 32'd1);
        for (int k = 0; k < 10 && !br_ready_o; k++) sync();
        br_valid_i = 1'b1; #1;
        chk("t5_old_read", {31'd0, pred_taken_o}, 32'd1);
        sync();
        br_valid_i = 1'b0; #1;
        chk("t5_new_read", {31'd0, pred_taken_o}, 32'd0);
        for (int k = 0; k < 10 && !br_ready_o; k++) sync();

        // 6: reset during the first flush cycle aborts the sequence
        do_reset();
        sync();
        issue(BR, 3'd0, 32'h100, 32'h20, 32'h0, 1'b1, 1'b0, 1'b0, w);
        br_valid_i = 1'b0;
        sync();
        chk("t6_in_flush", {31'd0, flush_o}, 32'd1);
        reset = 1'b1;
        sync();
        reset = 1'b0; fetch_pc_i = 32'h100; #1;
        chk("t6_flush", {31'd0, flush_o}, 32'd0);
        chk("t6_redirect", {31'd0, redirect_o}, 32'd0);
        chk("t6_ready", {31'd0, br_ready_o}, 32'd1);
        chk("t6_cnt", mispred_cnt_o, 32'd0);
        chk("t6_bht", {31'd0, pred_taken_o}, 32'd0);
        sync();

        // random traffic, checked every cycle by the model
        for (int c = 0; c < 1500; c++) begin
            reset = ($urandom_range(0, 149) == 0);
            fetch_pc_i = $urandom() & 32'h0000_00FC;
            if (!(br_valid_i && !m_acc)) begin
                sel = $urandom_range(0, 9);
                opcode_i = (sel < 5) ? BR : (sel < 7) ? JAL : (sel < 8) ? JALR : 7'($urandom());
                funct3_i = 3'($urandom());
                pc_i = ($urandom_range(0, 2) == 0) ? ($urandom() & 32'hFFFF_FFFC)
                                                   : ($urandom() & 32'h0000_007C);
                iv = int'($urandom_range(0, 4095)) - 2048;
                imm_i = 32'(iv);
                rs1_i = $urandom();
                breq_i = 1'($urandom()); brlt_i = 1'($urandom());
                pred_taken_i = 1'($urandom());
                br_valid_i = ($urandom_range(0, 9) < 7);
            end
            sync();
        end
        reset = 1'b0; br_valid_i = 1'b0;
        repeat (6) sync();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
